key_debounce_pulse: RTL and testbench
=====================================

Name: key_debounce_pulse

Overview:
Conditions a raw, asynchronous push-button or switch level so it can drive the board's D flip-flop and counter stages. The block synchronises the input and rejects bounce with a confirm-counter FSM. It outputs a clean registered level, single-cycle rise and fall pulses, and an 8-bit count of debounced presses. It sits directly upstream of the flip-flop lab stage: KEY_LVL or KEY_RISE feeds its D or clock-enable input.

Parameters:
DB_CYCLES, 1000000, consecutive CLK edges the synchronised input must hold a new value before it is accepted (20 ms at 50 MHz); minimum 2.
CNT_W, 20, width of the debounce counter; must satisfy 2**CNT_W >= DB_CYCLES.

Ports:
CLK  input  1  system clock, all state updates on its rising edge
RST  input  1  reset, synchronous, active-high
KEY_IN  input  1  raw key level, asynchronous to CLK, 1 = pressed
KEY_LVL  output  1  debounced key level, registered
KEY_RISE  output  1  one-cycle pulse when KEY_LVL goes 0->1
KEY_FALL  output  1  one-cycle pulse when KEY_LVL goes 1->0
PRESS_CNT  output  8  count of debounced rises, wraps modulo 256

Behaviour:
- Reset: one clock, synchronous, active-high.
  - RST sampled high on a CLK edge clears sync1, sync2, the counter, KEY_LVL, KEY_RISE, KEY_FALL and PRESS_CNT to 0; state <= S_LOW.
  - RST has priority over every other event on the same edge.
- Synchroniser:
  - sync1 <= KEY_IN; sync2 <= sync1.
  - Only sync2 is used by the FSM.
- FSM states: S_LOW (stable 0), S_RISE_CHK, S_HIGH (stable 1), S_FALL_CHK.
- S_LOW:
  - sync2 = 1: go to S_RISE_CHK, cnt <= 1.
  - Otherwise hold, cnt <= 0.
- S_RISE_CHK:
  - sync2 = 0: go to S_LOW, cnt <= 0. This is a bounce; no output change.
  - sync2 = 1 and cnt = DB_CYCLES-1: go to S_HIGH, KEY_LVL <= 1, KEY_RISE <= 1, PRESS_CNT <= PRESS_CNT+1, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- S_HIGH and S_FALL_CHK: mirror of the two states above with polarity inverted.
  - Acceptance sets KEY_LVL <= 0 and KEY_FALL <= 1.
  - PRESS_CNT is unchanged on a fall.
- Pulses:
  - KEY_RISE and KEY_FALL are high for exactly one cycle and default to 0 on every other edge.
  - They are never high together.
- Latency: let edge k be the first CLK edge that captures the new KEY_IN into sync1, with the input then held stable. The pulse and the KEY_LVL change are visible after edge k+1+DB_CYCLES.
- Acceptance condition: sync2 must be seen at the new value on DB_CYCLES consecutive FSM edges. Any single-edge reversal restarts the count from the stable state.
- PRESS_CNT wraps 255 -> 0 with no flag.
- Reset while KEY_IN is held high: after RST is released the press is treated as new. KEY_RISE fires after the full sync + debounce latency and PRESS_CNT becomes 1.
- The counter never exceeds DB_CYCLES-1. There is no overflow path.
- Unused state encodings recover to S_LOW on the next edge, with cnt cleared.

Decomposition:
- Shared package / header:
  - 2-bit state encodings S_LOW=00, S_RISE_CHK=01, S_HIGH=10, S_FALL_CHK=11
  - default DB_CYCLES constant
  - PRESS_CNT width constant (8)
- One natural sub-module: sync_2ff, a two-flop synchroniser with synchronous active-high clear. It is reusable for other board inputs.

Test Plan:
Run all scenarios with DB_CYCLES=4.
1. Reset: RST high for 2 edges, KEY_IN=0 -> KEY_LVL=0, KEY_RISE=0, KEY_FALL=0, PRESS_CNT=0, state S_LOW.
2. Clean press: KEY_IN 0->1 captured at edge k and held for 10 cycles -> KEY_RISE=1 only for the cycle after edge k+5, KEY_LVL=1 from then on, PRESS_CNT=1.
3. Bounce rejection: KEY_IN high 3 cycles, low 1, high 2, then low -> no KEY_RISE, KEY_LVL stays 0, PRESS_CNT stays 0.
4. Release: from scenario 2, KEY_IN 1->0 captured at edge j -> KEY_FALL=1 for one cycle after edge j+5, KEY_LVL=0, PRESS_CNT stays 1.
5. Wrap: 256 clean press/release pairs -> PRESS_CNT goes 255 -> 0 on the 256th KEY_RISE.
6. Reset mid-check: assert RST while in S_RISE_CHK (cnt=2, KEY_IN=1) and hold KEY_IN=1 -> all outputs 0 during reset. After RST drops, KEY_RISE fires one cycle after the 6th edge with RST low, and PRESS_CNT=1.

Source files
------------

// File: rtl/key_debounce_pulse_pkg.sv
// Shared definitions for the key debounce block: FSM state encoding,
// default debounce length and press-counter width.
package key_debounce_pulse_pkg;

  // 20 ms at 50 MHz
  localparam int unsigned DB_CYCLES_DEF = 1000000;
  localparam int unsigned CNT_W_DEF     = 20;
  localparam int unsigned PRESS_W       = 8;

  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_RISE_CHK = 2'b01,
    S_HIGH     = 2'b10,
    S_FALL_CHK = 2'b11
  } db_state_t;

endpackage

// File: rtl/key_debounce_pulse_if.sv
// Key-side signal bundle of the debounce block.
//   KEY_IN    raw asynchronous key level (1 = pressed)
//   KEY_LVL   debounced registered level
//   KEY_RISE  one-cycle pulse on a debounced 0->1
//   KEY_FALL  one-cycle pulse on a debounced 1->0
//   PRESS_CNT count of debounced rises, wraps modulo 256
// master: drives the raw key, observes results. slave: the debouncer.
interface key_debounce_pulse_if;
  import key_debounce_pulse_pkg::*;

  logic               KEY_IN;
  logic               KEY_LVL;
  logic               KEY_RISE;
  logic               KEY_FALL;
  logic [PRESS_W-1:0] PRESS_CNT;

  modport master (
    output KEY_IN,
    input  KEY_LVL, KEY_RISE, KEY_FALL, PRESS_CNT
  );

  modport slave (
    input  KEY_IN,
    output KEY_LVL, KEY_RISE, KEY_FALL, PRESS_CNT
  );
endinterface

// File: rtl/key_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser with synchronous active-high clear, for any
// asynchronous board input.
//   i_clk  clock
//   i_clr  synchronous clear, active-high
//   i_d    asynchronous input
//   o_q    synchronised output (two flops after i_d)
module sync_2ff (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/key_debounce_pulse.sv
// Key debouncer: synchronises a raw key level and accepts a new level only
// after it has been seen for DB_CYCLES consecutive clocks. Produces a
// registered level, one-cycle rise/fall pulses and a press counter.
//   CLK  clock, all state on rising edge
//   RST  synchronous active-high reset
//   KEY  key signal bundle (slave side)
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  key_debounce_pulse_if.slave   KEY
);

  logic               w_sync;
  logic               w_cnt_done;

  db_state_t          r_state;
  db_state_t          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_lvl;
  logic               w_lvl_nxt;
  logic               r_rise;
  logic               w_rise_nxt;
  logic               r_fall;
  logic               w_fall_nxt;
  logic [PRESS_W-1:0] r_press;
  logic [PRESS_W-1:0] w_press_nxt;

  sync_2ff u_sync (
    .i_clk (CLK),
    .i_clr (RST),
    .i_d   (KEY.KEY_IN),
    .o_q   (w_sync)
  );

  assign w_cnt_done = (r_cnt == CNT_W'(DB_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_press <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lvl   <= w_lvl_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_press <= w_press_nxt;
    end
  end

  // Counter defaults to zero so every path that leaves a check state, or
  // sits in a stable state, restarts the confirm count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_lvl_nxt   = r_lvl;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_press_nxt = r_press;
    case (r_state)
      S_LOW: begin
        if (w_sync) begin
          w_state_nxt = S_RISE_CHK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_RISE_CHK: begin
        if (!w_sync) begin
          w_state_nxt = S_LOW;
        end else if (w_cnt_done) begin
          w_state_nxt = S_HIGH;
          w_lvl_nxt   = 1'b1;
          w_rise_nxt  = 1'b1;
          w_press_nxt = r_press + PRESS_W'(1);
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = S_FALL_CHK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_FALL_CHK: begin
        if (w_sync) begin
          w_state_nxt = S_HIGH;
        end else if (w_cnt_done) begin
          w_state_nxt = S_LOW;
          w_lvl_nxt   = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOW;
      end
    endcase
  end

  assign KEY.KEY_LVL   = r_lvl;
  assign KEY.KEY_RISE  = r_rise;
  assign KEY.KEY_FALL  = r_fall;
  assign KEY.PRESS_CNT = r_press;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse with DB_CYCLES=4. Reference model: the FSM
// input is the key level captured two edges earlier; a level is accepted
// once it has differed from the current level on DB consecutive edges.
module tb_key_debounce_pulse;
  localparam int unsigned DB = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  key_debounce_pulse_if kif ();

  key_debounce_pulse #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .KEY (kif)
  );

  always #5 CLK = ~CLK;

  logic        m_lvl, m_rise, m_fall;
  logic [7:0]  m_cnt;
  int unsigned m_run;
  logic        hist[$];

  function automatic logic [10:0] obs();
    return {kif.KEY_LVL, kif.KEY_RISE, kif.KEY_FALL, kif.PRESS_CNT};
  endfunction

  function automatic logic [10:0] want();
    return {m_lvl, m_rise, m_fall, m_cnt};
  endfunction

  // Drive one clock of stimulus, advance the reference model, settle.
  task automatic tick(input logic key, input logic rst);
    logic s2;
    @(negedge CLK);
    kif.KEY_IN = key;
    RST        = rst;
    @(posedge CLK);
    if (rst) begin
      hist.delete();
      m_lvl = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_cnt = '0; m_run = 0;
    end else begin
      s2 = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(key);
      if (hist.size() > 2) void'(hist.pop_front());
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s2 != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          m_lvl = s2;
          m_run = 0;
          if (s2) begin
            m_rise = 1'b1;
            m_cnt  = m_cnt + 8'd1;
          end else begin
            m_fall = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    n_checks++;
    if (obs() !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: actual %h required %h", obs(), 11'h0);
    end
    n_checks++;
    if (dut.r_state !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: actual %b required 00", dut.r_state);
    end
  endtask

  task automatic test_clean_press();
    int rise_at = -1;
    int rises   = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (obs() !== want()) begin
        n_fail++;
        $display("FAIL press_cycle %0d: actual %h required %h", i, obs(), want());
      end
      if (kif.KEY_RISE === 1'b1) begin rise_at = i; rises++; end
    end
    n_checks++;
    if (rise_at != 6 || rises != 1) begin
      n_fail++;
      $display("FAIL press_latency: actual at=%0d n=%0d required at=6 n=1", rise_at, rises);
    end
    n_checks++;
    if (kif.KEY_LVL !== 1'b1 || kif.PRESS_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL press_final: actual lvl=%b cnt=%0d required lvl=1 cnt=1", kif.KEY_LVL, kif.PRESS_CNT);
    end
  endtask

  task automatic test_release();
    int fall_at = -1;
    int falls   = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (obs() !== want()) begin
        n_fail++;
        $display("FAIL release_cycle %0d: actual %h required %h", i, obs(), want());
      end
      if (kif.KEY_FALL === 1'b1) begin fall_at = i; falls++; end
    end
    n_checks++;
    if (fall_at != 6 || falls != 1 || kif.KEY_LVL !== 1'b0 || kif.PRESS_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL release_result: actual at=%0d n=%0d lvl=%b cnt=%0d required at=6 n=1 lvl=0 cnt=1",
               fall_at, falls, kif.KEY_LVL, kif.PRESS_CNT);
    end
  endtask

  task automatic test_bounce();
    logic pat [14];
    int   rises = 0;
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    test_reset();
    for (int i = 0; i < 14; i++) begin
      tick(pat[i], 1'b0);
      n_checks++;
      if (obs() !== want()) begin
        n_fail++;
        $display("FAIL bounce_cycle %0d: actual %h required %h", i, obs(), want());
      end
      if (kif.KEY_RISE === 1'b1) rises++;
    end
    n_checks++;
    if (rises != 0 || kif.KEY_LVL !== 1'b0 || kif.PRESS_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL bounce_reject: actual rises=%0d lvl=%b cnt=%0d required 0 0 0",
               rises, kif.KEY_LVL, kif.PRESS_CNT);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    for (int p = 1; p <= 256; p++) begin
      for (int i = 0; i < 14; i++) begin
        tick((i < 7) ? 1'b1 : 1'b0, 1'b0);
        n_checks++;
        if (obs() !== want()) begin
          n_fail++;
          $display("FAIL wrap_cycle p=%0d i=%0d: actual %h required %h", p, i, obs(), want());
        end
      end
      if (p == 255) begin
        n_checks++;
        if (kif.PRESS_CNT !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255: actual %0d required 255", kif.PRESS_CNT);
        end
      end
    end
    n_checks++;
    if (kif.PRESS_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: actual %0d required 0", kif.PRESS_CNT);
    end
  endtask

  task automatic test_random();
    logic        key;
    int unsigned hold;
    for (int s = 0; s < 80; s++) begin
      key  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 8);
      for (int unsigned h = 0; h < hold; h++) begin
        tick(key, 1'b0);
        n_checks++;
        if (obs() !== want() || (kif.KEY_RISE & kif.KEY_FALL) !== 1'b0) begin
          n_fail++;
          $display("FAIL random_seg %0d: actual %h required %h", s, obs(), want());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rise_at = -1;
    test_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    n_checks++;
    if (dut.r_state !== 2'b01 || dut.r_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL midchk_setup: actual state=%b cnt=%0d required 01 2", dut.r_state, dut.r_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (obs() !== 11'h0) begin
        n_fail++;
        $display("FAIL midchk_reset %0d: actual %h required %h", i, obs(), 11'h0);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (obs() !== want()) begin
        n_fail++;
        $display("FAIL midchk_cycle %0d: actual %h required %h", i, obs(), want());
      end
      if (kif.KEY_RISE === 1'b1) rise_at = i;
    end
    n_checks++;
    if (rise_at != 6 || kif.PRESS_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL midchk_rise: actual at=%0d cnt=%0d required at=6 cnt=1", rise_at, kif.PRESS_CNT);
    end
  endtask

  initial begin
    kif.KEY_IN = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
